writeback: RTL

//  Commit stage directly downstream of execute. Latches each result beat
//  (opnd0_w, o_eflags, destination info) into a 1-deep pending register.
//  On the following cycle it merges the result into the architectural GPR

---
 rtl/writeback.sv | 134 +++++++++++++
 1 files changed

// File: rtl/writeback.sv
// writeback: commit stage with a 1-deep pending register, GPR/EFLAGS merge and HLT halting.
// Optional WRITEBACK_BYPASS_EN forwards the pending beat's post-merge value to the read ports and eflags.
module writeback #(
    parameter logic [31:0] EFLAGS_RST = 32'h0000_0002,
    parameter int          NREGS      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_gpr_wr,
    input  logic [2:0]  in_dst,
    input  logic [1:0]  in_width,
    input  logic [31:0] in_data,
    input  logic        in_flags_wr,
    input  logic [31:0] in_eflags,
    input  logic        in_halt,
    input  logic [2:0]  rd0_sel,
    output logic [31:0] rd0_data,
    input  logic [2:0]  rd1_sel,
    output logic [31:0] rd1_data,
    output logic [31:0] eflags,
    output logic        wb_busy,
    output logic [31:0] retire_count,
    output logic        halted,
    output logic        err_width
);
    // state  | meaning
    // RUN    | accepting beats
    // DRAIN  | HLT accepted; its pending beat commits this cycle
    // HALTED | stopped, no beats accepted until rst
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    // reserved EFLAGS bits that always read as zero: 31:22, 15, 5, 3
    localparam logic [31:0] EFLAGS_ZERO = 32'hFFC0_8028;

    state_t      state, state_nx;
    logic [31:0] gpr [NREGS];
    logic [31:0] eflags_q;
    logic        p_valid, p_gpr_wr, p_flags_wr;
    logic [2:0]  p_dst;
    logic [1:0]  p_width;
    logic [31:0] p_data, p_eflags;
    logic        accept;
    logic [2:0]  tgt;
    logic [31:0] merged;
    logic        merge_en;
    logic [31:0] p_flags_clean;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (accept && in_halt) state_nx = DRAIN;
            DRAIN:   state_nx = HALTED;
            HALTED:  state_nx = HALTED;
            default: state_nx = RUN;
        endcase
    end

    always_comb begin
        in_ready = (state == RUN);
        halted   = (state == HALTED);
    end

    assign accept  = in_valid & in_ready;
    assign wb_busy = p_valid;

    // high-byte writes (AH..BH) land in bits 15:8 of register dst-4
    always_comb begin
        tgt = p_dst;
        if (p_width == 2'b00 && p_dst[2]) tgt = {1'b0, p_dst[1:0]};
        merged = gpr[tgt];
        case (p_width)
            2'b00: begin
                if (p_dst[2]) merged[15:8] = p_data[7:0];
                else          merged[7:0]  = p_data[7:0];
            end
            2'b01:   merged[15:0] = p_data[15:0];
            2'b10:   merged = p_data;
            default: merged = gpr[tgt];
        endcase
    end

    assign merge_en      = p_valid & p_gpr_wr & (p_width != 2'b11);
    assign p_flags_clean = (p_eflags & ~EFLAGS_ZERO) | 32'h0000_0002;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_valid      <= 1'b0;
            p_gpr_wr     <= 1'b0;
            p_flags_wr   <= 1'b0;
            p_dst        <= '0;
            p_width      <= '0;
            p_data       <= '0;
            p_eflags     <= '0;
            eflags_q     <= EFLAGS_RST;
            retire_count <= '0;
            err_width    <= 1'b0;
            for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
        end else begin
            p_valid <= accept;
            if (accept) begin
                p_gpr_wr   <= in_gpr_wr;
                p_flags_wr <= in_flags_wr;
                p_dst      <= in_dst;
                p_width    <= in_width;
                p_data     <= in_data;
                p_eflags   <= in_eflags;
            end
            if (p_valid) begin
                retire_count <= retire_count + 32'd1;
                if (merge_en)             gpr[tgt]  <= merged;
                if (p_flags_wr)           eflags_q  <= p_flags_clean;
                if (p_width == 2'b11)     err_width <= 1'b1;
            end
        end
    end

`ifdef WRITEBACK_BYPASS_EN
    assign rd0_data = (merge_en && rd0_sel == tgt) ? merged : gpr[rd0_sel];
    assign rd1_data = (merge_en && rd1_sel == tgt) ? merged : gpr[rd1_sel];
    assign eflags   = (p_valid && p_flags_wr) ? p_flags_clean : eflags_q;
`else
    assign rd0_data = gpr[rd0_sel];
    assign rd1_data = gpr[rd1_sel];
    assign eflags   = eflags_q;
`endif

endmodule
